pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the IF/ID register controls (nowrite, flush) plus PC write-enable and the ID/EX, EX/MEM and MEM/WB freeze/bubble controls.
- Handles load-use hazards, taken-branch redirects, data-cache miss waits (req/done handshake) and the halt drain sequence.
- Sits beside the pipeline registers and is the only source of their control inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: FSM state encoding, NOP instruction word, register-index width.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  // Word the IF/ID register loads when if_flush is asserted.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int REG_W = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - W-bit saturating event counter
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-low reset, clears count
//   inc   in  count one event this cycle
//   count out current value, sticks at all-ones
module pipe_hazard_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   id_rs/id_rt/_used, id_halt     ID-stage operand and halt information
//   ex_mem_read, ex_rd, ex_redirect EX-stage load/destination/taken-branch
//   mem_req, mem_done              dcache handshake from MEM stage
//   pc_write, pc_redirect          PC enable and branch-target select
//   if_id_nowrite, if_flush        IF/ID hold and NOP load
//   id_ex_bubble, id_ex_nowrite    ID/EX bubble and hold
//   ex_mem_nowrite, mem_wb_nowrite EX/MEM and MEM/WB hold
//   halted, mem_err                halt reached, sticky dcache timeout
//   stall_cnt, flush_cnt           saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             if_id_nowrite,
  output logic             if_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_nowrite,
  output logic             ex_mem_nowrite,
  output logic             mem_wb_nowrite,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt, eff_state;
  logic          ret_drain, ret_drain_nxt;  // MEM_WAIT returns to DRAIN instead of RUN
  logic [DW-1:0] drain_cnt;
  logic [TW-1:0] to_cnt;
  logic          freeze, load_use;
  logic          stall_inc, flush_inc, drain_inc;

  assign freeze = (((state == ST_RUN) || (state == ST_DRAIN)) && mem_req && !mem_done) ||
                  ((state == ST_MEM_WAIT) && !mem_done);

  assign load_use = ex_mem_read &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

  // The mem_done cycle of MEM_WAIT is unfrozen and behaves like the state it returns to.
  assign eff_state = (state == ST_MEM_WAIT) ? (ret_drain ? ST_DRAIN : ST_RUN) : state;

  assign halted = (state == ST_HALTED);

  always_comb begin
    state_nxt      = state;
    ret_drain_nxt  = ret_drain;
    pc_write       = 1'b0;
    pc_redirect    = 1'b0;
    if_id_nowrite  = 1'b0;
    if_flush       = 1'b0;
    id_ex_bubble   = 1'b0;
    id_ex_nowrite  = 1'b0;
    ex_mem_nowrite = 1'b0;
    mem_wb_nowrite = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    drain_inc      = 1'b0;
    if (state == ST_HALTED) begin
      if_id_nowrite  = 1'b1;
      id_ex_nowrite  = 1'b1;
      ex_mem_nowrite = 1'b1;
      mem_wb_nowrite = 1'b1;
    end else if (freeze) begin
      if_id_nowrite  = 1'b1;
      id_ex_nowrite  = 1'b1;
      ex_mem_nowrite = 1'b1;
      mem_wb_nowrite = 1'b1;
      state_nxt      = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) begin
        ret_drain_nxt = (state == ST_DRAIN);
      end
      stall_inc = (state != ST_DRAIN);
    end else if (eff_state == ST_DRAIN) begin
      if_flush  = 1'b1;
      drain_inc = 1'b1;
      state_nxt = (drain_cnt == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
    end else begin
      state_nxt = ST_RUN;
      // The ID instruction is wrong-path on a redirect, so its hazards are moot.
      if (ex_redirect) begin
        pc_redirect  = 1'b1;
        pc_write     = 1'b1;
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        if_id_nowrite = 1'b1;
        id_ex_bubble  = 1'b1;
        stall_inc     = 1'b1;
      end else if (id_halt) begin
        if_flush  = 1'b1;
        state_nxt = ST_DRAIN;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_drain <= 1'b0;
      drain_cnt <= '0;
      to_cnt    <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_drain <= ret_drain_nxt;
      if (drain_inc) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
      // Only frozen MEM_WAIT cycles count toward the timeout; the FSM keeps waiting.
      if ((state == ST_MEM_WAIT) && !mem_done) begin
        if (to_cnt == TO_LAST) begin
          mem_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // Control vector: {pc_write, pc_redirect, if_id_nowrite, if_flush, id_ex_bubble,
  //                  id_ex_nowrite, ex_mem_nowrite, mem_wb_nowrite, halted, mem_err}
  localparam logic [9:0] C_IDLE = 10'b1_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] C_FRZ  = 10'b0_0_1_0_0_1_1_1_0_0;
  localparam logic [9:0] C_LU   = 10'b0_0_1_0_1_0_0_0_0_0;
  localparam logic [9:0] C_RD   = 10'b1_1_0_1_1_0_0_0_0_0;
  localparam logic [9:0] C_FL   = 10'b0_0_0_1_0_0_0_0_0_0;
  localparam logic [9:0] C_HLT  = 10'b0_0_1_0_0_1_1_1_1_0;
  localparam logic [9:0] C_ERR  = 10'b0_0_0_0_0_0_0_0_0_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_rs_used, id_rt_used, id_halt, ex_mem_read, ex_redirect, mem_req, mem_done;
  logic        pc_write, pc_redirect, if_id_nowrite, if_flush, id_ex_bubble;
  logic        id_ex_nowrite, ex_mem_nowrite, mem_wb_nowrite, halted, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0]  ctl;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_redirect, if_id_nowrite, if_flush, id_ex_bubble,
                id_ex_nowrite, ex_mem_nowrite, mem_wb_nowrite, halted, mem_err};

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .id_halt        (id_halt),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_done       (mem_done),
    .pc_write       (pc_write),
    .pc_redirect    (pc_redirect),
    .if_id_nowrite  (if_id_nowrite),
    .if_flush       (if_flush),
    .id_ex_bubble   (id_ex_bubble),
    .id_ex_nowrite  (id_ex_nowrite),
    .ex_mem_nowrite (ex_mem_nowrite),
    .mem_wb_nowrite (mem_wb_nowrite),
    .halted         (halted),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_halt = 1'b0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs are checked at the falling edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check(tag, {22'd0, ctl}, {22'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    check("reset_stall", {16'd0, stall_cnt}, 32'd0);
    check("reset_flush", {16'd0, flush_cnt}, 32'd0);
    rst = 1'b1;
    cyc("idle", C_IDLE);

    // Load-use on rs, then on rt, then an unused-operand match that is no hazard
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    cyc("lu_rs", C_LU);
    clr();
    cyc("lu_rs_after", C_IDLE);
    check("lu_stall1", {16'd0, stall_cnt}, 32'd1);
    ex_mem_read = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_rt_used = 1'b1; id_rs = 3'd1; id_rs_used = 1'b1;
    cyc("lu_rt", C_LU);
    clr();
    ex_mem_read = 1'b1; ex_rd = 3'd5; id_rs = 3'd5; id_rs_used = 1'b0; id_rt = 3'd2; id_rt_used = 1'b1;
    cyc("lu_unused", C_IDLE);
    clr();
    check("lu_stall2", {16'd0, stall_cnt}, 32'd2);

    // Redirect beats load-use
    pulse_reset();
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_used = 1'b1;
    cyc("rd_lu", C_RD);
    clr();
    cyc("rd_after", C_IDLE);
    check("rd_flush", {16'd0, flush_cnt}, 32'd1);
    check("rd_stall", {16'd0, stall_cnt}, 32'd0);

    // 4-cycle dcache miss; a redirect during the freeze is ignored
    pulse_reset();
    mem_req = 1'b1;
    cyc("frz1", C_FRZ);
    ex_redirect = 1'b1;
    cyc("frz2_rd", C_FRZ);
    ex_redirect = 1'b0;
    cyc("frz3", C_FRZ);
    cyc("frz4", C_FRZ);
    mem_done = 1'b1;
    cyc("frz_done", C_IDLE);
    check("frz_stall", {16'd0, stall_cnt}, 32'd4);
    check("frz_flush", {16'd0, flush_cnt}, 32'd0);
    cyc("req_done", C_IDLE);
    clr();
    cyc("req_done_after", C_IDLE);
    check("req_done_stall", {16'd0, stall_cnt}, 32'd4);

    // Halt drain, then asynchronous reset out of HALTED
    pulse_reset();
    id_halt = 1'b1;
    cyc("halt_id", C_FL);
    id_halt = 1'b0;
    cyc("drain1", C_FL);
    cyc("drain2", C_FL);
    cyc("drain3", C_FL);
    cyc("halted", C_HLT);
    cyc("halted_hold", C_HLT);
    rst = 1'b0;
    #1;
    check("rst_halt_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    rst = 1'b1;
    cyc("rst_halt_run", C_IDLE);

    // Halt drain stretched by a 2-cycle dcache stall
    id_halt = 1'b1;
    cyc("halt2_id", C_FL);
    id_halt = 1'b0;
    cyc("drain2_1", C_FL);
    mem_req = 1'b1;
    cyc("drain2_frz1", C_FRZ);
    cyc("drain2_frz2", C_FRZ);
    mem_done = 1'b1;
    cyc("drain2_2", C_FL);
    clr();
    cyc("drain2_3", C_FL);
    cyc("halted2", C_HLT);

    // Dcache timeout with MEM_TIMEOUT=4
    pulse_reset();
    mem_req = 1'b1;
    cyc("to_run", C_FRZ);
    cyc("to_mw1", C_FRZ);
    cyc("to_mw2", C_FRZ);
    cyc("to_mw3", C_FRZ);
    cyc("to_mw4", C_FRZ);
    cyc("to_err", C_FRZ | C_ERR);
    mem_done = 1'b1;
    cyc("to_done", C_IDLE | C_ERR);
    clr();
    cyc("to_sticky", C_IDLE | C_ERR);

    // Asynchronous reset in the middle of MEM_WAIT
    mem_req = 1'b1;
    cyc("mw_enter", C_FRZ | C_ERR);
    cyc("mw_wait", C_FRZ | C_ERR);
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check("rst_mw_ctl", {22'd0, ctl}, {22'd0, C_IDLE});
    check("rst_mw_stall", {16'd0, stall_cnt}, 32'd0);
    check("rst_mw_flush", {16'd0, flush_cnt}, 32'd0);
    rst = 1'b1;
    cyc("rst_mw_run", C_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
